instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly upstream of the RV64IM decoder. Issues aligned 64-bit reads to the instruction memory port and splits each returned line into two 32-bit instructions. Presents each instruction with its PC to the decoder over a valid/ready handshake. Supports PC redirection from the jump/branch path and stops on an all-zero instruction word.

## Interface
Parameters:
- ENTRY_PC, 64'h0, PC loaded at reset; bits [1:0] must be 0.
- ADDR_W, 64, address/PC width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- rd_req_valid  output  1  memory read request valid
- rd_req_ready  input  1  memory accepts request
- rd_req_addr  output  ADDR_W  line address, bits [2:0] always 0
- rd_resp_valid  input  1  read data valid (one pulse per accepted request)
- rd_resp_data  input  64  line; [31:0] at addr, [63:32] at addr+4
- ir_valid  output  1  instruction available
- ir_ready  input  1  decoder consumes instruction
- ir  output  32  instruction word
- ir_pc  output  ADDR_W  address of ir
- redirect_valid  input  1  load new PC (jump/branch taken)
- redirect_pc  input  ADDR_W  new PC; bits [1:0] ignored (forced 0)
- halted  output  1  all-zero instruction consumed; fetch stopped

## Operation
- States:
  - REQ: drive rd_req_valid with addr = {pc[63:3],3'b0}; go to WAIT on rd_req_ready.
  - WAIT: await rd_resp_valid; capture the line; go to DRAIN.
  - DRAIN: present halves in order.
  - FLUSH: swallow one stale response, then go to REQ.
  - HALT.
- Half mask on capture: both halves if pc[2]=0, high half only if pc[2]=1.
- DRAIN presents the lowest valid half: ir = that half, ir_pc = pc.
- On ir_valid&&ir_ready:
  - clear that half; pc += 4.
  - If ir==32'h0: go to HALT and assert halted.
  - Otherwise, if no half remains: go to REQ.
- At most one outstanding request. No prefetch during DRAIN.
- Redirect (any state, highest priority):
  - pc <= {redirect_pc[63:2],2'b0}; clear the line buffer; clear halted.
  - If a request was accepted and its response has not yet arrived, go to FLUSH. A response arriving in the same cycle as the redirect is discarded and the next state is REQ.
  - Otherwise go to REQ.
- Redirect in the same cycle as an ir handshake: the handshake counts as consumed (the decoder has the word); the redirect still wins for pc and state. A halt caused by that word is overridden by the redirect.
- rd_resp_valid outside WAIT/FLUSH is ignored.

## Timing
- Reset values:
  - state=REQ, pc=ENTRY_PC.
  - rd_req_valid=0 during reset. rd_req_addr=0 during reset.
  - ir_valid=0, ir=0, ir_pc=0, halted=0.
- First rd_req_valid is asserted in the first cycle after reset deasserts.
- rd_req_valid and rd_req_addr are held stable until rd_req_ready.
- Response captured at the clock edge where rd_resp_valid=1. ir_valid rises the next cycle, giving 1-cycle response-to-instruction latency.
- ir, ir_pc and ir_valid are registered and held stable while ir_valid && !ir_ready.
- Back-to-back halves: second half valid in the cycle after the first is consumed.
- After the last half is consumed, rd_req_valid asserts the next cycle.
- Redirect:
  - ir_valid=0 the cycle after redirect_valid.
  - New request the cycle after redirect when not flushing.
- Reset mid-operation: all state returns to reset values. Any in-flight response after reset is treated as stale only if it arrives in FLUSH; the bench must not return responses for requests accepted before reset.
- Width rules: pc arithmetic is modulo 2^ADDR_W. Wrap from all-ones-minus-3 to 0 is legal.

## Structure
- Shared package fetch_pkg:
  - state enum {REQ, WAIT, DRAIN, FLUSH, HALT}
  - INSN_BYTES=4, LINE_BYTES=8
  - NOP_HALT_WORD=32'h0
- One natural sub-module: fetch_line_buffer (64-bit line register plus 2-bit half-valid mask; load, pop, clear).
- FSM and pc live in instruction_fetch.

## Test plan
- Straight line: ENTRY_PC=0x1000, memory returns 0x00a0051300100093 at 0x1000. Expect ir=0x00100093 at pc 0x1000, then ir=0x00a00513 at 0x1004, then a request to 0x1008.
- Backpressure: hold ir_ready=0 for 5 cycles. ir/ir_pc are held stable, no new request is issued, and no instruction is dropped or duplicated.
- Misaligned redirect: redirect_pc=0x2004. Request 0x2000; only the high half is emitted, with ir_pc=0x2004.
- Redirect while in WAIT: redirect_pc=0x3000. The stale 0x1008 response is swallowed, the next request is 0x3000, and no stale ir is presented.
- Halt: a line with high half 0x00000000. After that word is consumed, halted=1 and no rd_req_valid for 20 cycles. A redirect to 0x1000 clears halted and resumes fetch.
- Reset during DRAIN: all outputs return to reset values, and the next request is to ENTRY_PC in the cycle after reset deasserts.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, line and
// instruction geometry, the halt word, and a helper to select a line half.
package fetch_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned LINE_W     = 64;

  localparam logic [INSN_W-1:0] NOP_HALT_WORD = 32'h0;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    DRAIN,
    FLUSH,
    HALT
  } state_e;

  // Half 0 is the word at the line address, half 1 the word at +4.
  function automatic logic [INSN_W-1:0] line_half(input logic [LINE_W-1:0] line,
                                                  input logic              hi);
    return hi ? line[LINE_W-1:INSN_W] : line[INSN_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One fetched 64-bit line plus a per-half valid mask.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_i          capture load_data_i; load_hi_only_i marks only half 1 valid
//   pop_i           clear the half selected by pop_hi_i
//   clear_i         drop both halves (highest priority)
//   line_o, mask_o  stored line and half-valid mask (bit 0 = low half)
module fetch_line_buffer
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [LINE_W-1:0] load_data_i,
  input  logic              load_hi_only_i,
  input  logic              pop_i,
  input  logic              pop_hi_i,
  input  logic              clear_i,
  output logic [LINE_W-1:0] line_o,
  output logic [1:0]        mask_o
);

  logic [LINE_W-1:0] line_q, line_d;
  logic [1:0]        mask_q, mask_d;

  // Next line/mask: clear beats load beats pop.
  always_comb begin
    line_d = line_q;
    mask_d = mask_q;
    if (clear_i) begin
      mask_d = 2'b00;
    end else if (load_i) begin
      line_d = load_data_i;
      mask_d = load_hi_only_i ? 2'b10 : 2'b11;
    end else if (pop_i) begin
      mask_d = mask_q & (pop_hi_i ? 2'b01 : 2'b10);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
      mask_q <= '0;
    end else begin
      line_q <= line_d;
      mask_q <= mask_d;
    end
  end

  assign line_o = line_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues aligned 64-bit line reads, splits each line into two
// 32-bit instructions and hands them to the decoder with their PC.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rd_req_valid/ready/addr         line read request (one outstanding max)
//   rd_resp_valid/data              line read response
//   ir_valid/ready, ir, ir_pc       instruction to decoder
//   redirect_valid, redirect_pc     taken jump/branch target
//   halted                          all-zero word consumed, fetch stopped
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  ENTRY_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_resp_valid,
  input  logic [LINE_W-1:0] rd_resp_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [INSN_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rd_req_valid_q;
  logic [ADDR_W-1:0] rd_req_addr_q;
  logic              ir_valid_q, ir_valid_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              halted_q, halted_d;

  logic              buf_load, buf_pop, buf_clear;
  logic [LINE_W-1:0] buf_line;
  logic [1:0]        buf_mask;
  logic              req_fire, ir_fire;

  fetch_line_buffer u_line_buffer (
    .clk            (clk),
    .reset          (reset),
    .load_i         (buf_load),
    .load_data_i    (rd_resp_data),
    .load_hi_only_i (pc_q[2]),
    .pop_i          (buf_pop),
    .pop_hi_i       (pc_q[2]),
    .clear_i        (buf_clear),
    .line_o         (buf_line),
    .mask_o         (buf_mask)
  );

  // rd_req_valid_q is only ever set while in REQ.
  assign req_fire = rd_req_valid_q && rd_req_ready;
  assign ir_fire  = ir_valid_q && ir_ready;

  // Next-state, pc and registered-output next values.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    halted_d   = halted_q;
    buf_load   = 1'b0;
    buf_pop    = 1'b0;
    buf_clear  = 1'b0;

    case (state_q)
      REQ: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (rd_resp_valid) begin
          buf_load   = 1'b1;
          state_d    = DRAIN;
          ir_valid_d = 1'b1;
          ir_d       = line_half(rd_resp_data, pc_q[2]);
          ir_pc_d    = pc_q;
        end
      end
      DRAIN: begin
        if (ir_fire) begin
          buf_pop = 1'b1;
          pc_d    = pc_q + ADDR_W'(INSN_BYTES);
          if (ir_q == NOP_HALT_WORD) begin
            state_d    = HALT;
            halted_d   = 1'b1;
            ir_valid_d = 1'b0;
          end else if ((buf_mask & (pc_q[2] ? 2'b01 : 2'b10)) != 2'b00) begin
            // Only the high half can remain after popping the low one.
            ir_d    = line_half(buf_line, ~pc_q[2]);
            ir_pc_d = pc_q + ADDR_W'(INSN_BYTES);
          end else begin
            state_d    = REQ;
            ir_valid_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (rd_resp_valid) state_d = REQ;
      end
      HALT: begin
      end
      default: state_d = REQ;
    endcase

    // Redirect overrides everything; an accepted request whose response is
    // still pending (including one accepted this cycle) must be swallowed.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~ADDR_W'(INSN_BYTES - 1);
      buf_clear  = 1'b1;
      halted_d   = 1'b0;
      ir_valid_d = 1'b0;
      if (((state_q == WAIT || state_q == FLUSH) && !rd_resp_valid) || req_fire) begin
        state_d = FLUSH;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= REQ;
      pc_q           <= ENTRY_PC;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      ir_valid_q     <= 1'b0;
      ir_q           <= '0;
      ir_pc_q        <= '0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      rd_req_valid_q <= (state_d == REQ);
      rd_req_addr_q  <= pc_d & ~ADDR_W'(LINE_BYTES - 1);
      ir_valid_q     <= ir_valid_d;
      ir_q           <= ir_d;
      ir_pc_q        <= ir_pc_d;
      halted_q       <= halted_d;
    end
  end

  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign ir_valid     = ir_valid_q;
  assign ir           = ir_q;
  assign ir_pc        = ir_pc_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a memory responder returns lines computed
// from an address-hash function, and a program-order model (expected PC,
// halted flag) checks every instruction handshake and every accepted request.
module tb_instruction_fetch;

  localparam logic [63:0] ENTRY     = 64'h1000;
  localparam logic [63:0] NO_HALT   = 64'hFFFF_FFFF_0000_0000;

  logic        clk;
  logic        reset;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [63:0] rd_req_addr;
  logic        rd_resp_valid;
  logic [63:0] rd_resp_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  int n_checks;
  int n_pass;

  // memory configuration (written by tasks)
  int          ready_pct;
  int          min_lat;
  int          max_lat;
  logic [63:0] halt_addr;

  // responder / model state (written only by the negedge process)
  logic        pending;
  logic [63:0] pend_addr;
  int          lat_cnt;
  logic [63:0] m_pc;
  logic        m_halted;
  int          n_hs;

  instruction_fetch #(
    .ADDR_W   (64),
    .ENTRY_PC (ENTRY)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_addr    (rd_req_addr),
    .rd_resp_valid  (rd_resp_valid),
    .rd_resp_data   (rd_resp_data),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory contents: fixed words at 0x1000, zero at halt_addr,
  // otherwise a nonzero hash of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == halt_addr) return 32'h0;
    if (a == 64'h1000) return 32'h0010_0093;
    if (a == 64'h1004) return 32'h00a0_0513;
    return ((a[31:0] * 32'h9E37_79B1) ^ 32'h5A00_0000) | 32'h1;
  endfunction

  // Memory responder plus reference model, evaluated away from the active
  // edge for the handshakes that will occur at the next rising edge.
  always @(negedge clk) begin
    logic [63:0] pc_now;
    logic [31:0] w;
    rd_resp_valid = 1'b0;
    if (reset) begin
      pending      = 1'b0;
      rd_req_ready = 1'b0;
      m_pc         = ENTRY;
      m_halted     = 1'b0;
    end else begin
      pc_now = m_pc;
      if (m_halted) begin
        n_checks++;
        if (halted !== 1'b1 || rd_req_valid !== 1'b0 || ir_valid !== 1'b0)
          $display("FAIL halted_idle: halted=%b rd_req_valid=%b ir_valid=%b, need 1/0/0",
                   halted, rd_req_valid, ir_valid);
        else n_pass++;
      end
      if (ir_valid && ir_ready) begin
        w = mem_word(pc_now);
        n_checks++;
        if (ir !== w || ir_pc !== pc_now)
          $display("FAIL ir_stream: ir=%h pc=%h, need ir=%h pc=%h", ir, ir_pc, w, pc_now);
        else n_pass++;
        n_hs++;
        m_pc = pc_now + 64'd4;
        if (w == 32'h0) m_halted = 1'b1;
      end
      if (redirect_valid) begin
        m_pc     = redirect_pc & ~64'd3;
        m_halted = 1'b0;
      end
      if (pending) begin
        if (lat_cnt == 0) begin
          rd_resp_valid = 1'b1;
          rd_resp_data  = {mem_word(pend_addr + 64'd4), mem_word(pend_addr)};
          pending       = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      rd_req_ready = !pending && ($urandom_range(99) < ready_pct);
      if (rd_req_valid && rd_req_ready) begin
        n_checks++;
        if (rd_req_addr !== (pc_now & ~64'd7))
          $display("FAIL req_addr: addr=%h, need %h", rd_req_addr, pc_now & ~64'd7);
        else n_pass++;
        pending   = 1'b1;
        pend_addr = rd_req_addr;
        lat_cnt   = $urandom_range(max_lat, min_lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rd_req_valid !== 1'b0 || rd_req_addr !== 64'h0 || ir_valid !== 1'b0 ||
        ir !== 32'h0 || ir_pc !== 64'h0 || halted !== 1'b0)
      $display("FAIL reset_outputs: req=%b addr=%h irv=%b ir=%h pc=%h halted=%b, need all 0",
               rd_req_valid, rd_req_addr, ir_valid, ir, ir_pc, halted);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (rd_req_valid !== 1'b1 || rd_req_addr !== ENTRY)
      $display("FAIL first_req: req=%b addr=%h, need 1 addr=%h", rd_req_valid, rd_req_addr, ENTRY);
    else n_pass++;
  endtask

  task automatic test_straight_line();
    int n;
    ready_pct = 100; min_lat = 0; max_lat = 0; ir_ready = 1'b0;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    n_checks++;
    if (ir_valid !== 1'b1 || ir !== 32'h0010_0093 || ir_pc !== 64'h1000)
      $display("FAIL straight_first: v=%b ir=%h pc=%h, need 1 00100093 1000", ir_valid, ir, ir_pc);
    else n_pass++;
    ir_ready = 1'b1;
    tick();
    n_checks++;
    if (ir_valid !== 1'b1 || ir !== 32'h00a0_0513 || ir_pc !== 64'h1004)
      $display("FAIL straight_second: v=%b ir=%h pc=%h, need 1 00a00513 1004", ir_valid, ir, ir_pc);
    else n_pass++;
    tick();
    ir_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || rd_req_valid !== 1'b1 || rd_req_addr !== 64'h1008)
      $display("FAIL straight_next_req: irv=%b req=%b addr=%h, need 0 1 1008",
               ir_valid, rd_req_valid, rd_req_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] ir0;
    logic [63:0] pc0;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    ir0 = ir; pc0 = ir_pc;
    n_checks++;
    if (ir_valid !== 1'b1 || pc0 !== 64'h1008 || ir0 !== mem_word(64'h1008))
      $display("FAIL bp_present: v=%b ir=%h pc=%h, need 1 %h 1008", ir_valid, ir0, pc0, mem_word(64'h1008));
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (ir_valid !== 1'b1 || ir !== ir0 || ir_pc !== pc0 || rd_req_valid !== 1'b0)
        $display("FAIL bp_hold: v=%b ir=%h pc=%h req=%b, need 1 %h %h 0",
                 ir_valid, ir, ir_pc, rd_req_valid, ir0, pc0);
      else n_pass++;
    end
    ir_ready = 1'b1;
    tick();
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 64'h100c)
      $display("FAIL bp_release: v=%b pc=%h, need 1 100c", ir_valid, ir_pc);
    else n_pass++;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic test_misaligned_redirect();
    int n;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    redirect_valid = 1'b1; redirect_pc = 64'h2004;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || rd_req_valid !== 1'b1 || rd_req_addr !== 64'h2000)
      $display("FAIL redir_req: irv=%b req=%b addr=%h, need 0 1 2000", ir_valid, rd_req_valid, rd_req_addr);
    else n_pass++;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 64'h2004 || ir !== mem_word(64'h2004))
      $display("FAIL redir_hi_half: v=%b ir=%h pc=%h, need 1 %h 2004", ir_valid, ir, ir_pc, mem_word(64'h2004));
    else n_pass++;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || rd_req_valid !== 1'b1 || rd_req_addr !== 64'h2008)
      $display("FAIL redir_one_half: irv=%b req=%b addr=%h, need 0 1 2008", ir_valid, rd_req_valid, rd_req_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_in_wait();
    int n;
    logic saw_ir;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    redirect_valid = 1'b1; redirect_pc = 64'h1004;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    min_lat = 4; max_lat = 4;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_checks++;
    if (rd_req_valid !== 1'b1 || rd_req_addr !== 64'h1008)
      $display("FAIL wait_req: req=%b addr=%h, need 1 1008", rd_req_valid, rd_req_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_req_valid !== 1'b0)
      $display("FAIL wait_accepted: req=%b, need 0", rd_req_valid);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    min_lat = 0; max_lat = 0;
    n_checks++;
    if (ir_valid !== 1'b0 || rd_req_valid !== 1'b0)
      $display("FAIL flush_quiet: irv=%b req=%b, need 0 0", ir_valid, rd_req_valid);
    else n_pass++;
    saw_ir = 1'b0;
    n = 0;
    while (!rd_req_valid && n < 30) begin tick(); saw_ir |= ir_valid; n++; end
    n_checks++;
    if (rd_req_valid !== 1'b1 || rd_req_addr !== 64'h3000 || saw_ir !== 1'b0)
      $display("FAIL flush_then_req: req=%b addr=%h stale_ir=%b, need 1 3000 0",
               rd_req_valid, rd_req_addr, saw_ir);
    else n_pass++;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    n_checks++;
    if (ir_pc !== 64'h3000 || ir !== mem_word(64'h3000))
      $display("FAIL flush_first_ir: ir=%h pc=%h, need %h 3000", ir, ir_pc, mem_word(64'h3000));
    else n_pass++;
  endtask

  task automatic test_halt();
    int n;
    min_lat = 0; max_lat = 2;
    halt_addr = 64'h4004;
    ir_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h4000;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!halted && n < 60) begin tick(); n++; end
    n_checks++;
    if (halted !== 1'b1)
      $display("FAIL halt_reached: halted=%b, need 1", halted);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (rd_req_valid !== 1'b0 || halted !== 1'b1 || ir_valid !== 1'b0)
        $display("FAIL halt_stays: req=%b halted=%b irv=%b, need 0 1 0", rd_req_valid, halted, ir_valid);
      else n_pass++;
    end
    ir_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h1000;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || rd_req_valid !== 1'b1 || rd_req_addr !== 64'h1000)
      $display("FAIL halt_resume: halted=%b req=%b addr=%h, need 0 1 1000", halted, rd_req_valid, rd_req_addr);
    else n_pass++;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    n_checks++;
    if (ir !== 32'h0010_0093 || ir_pc !== 64'h1000)
      $display("FAIL halt_resume_ir: ir=%h pc=%h, need 00100093 1000", ir, ir_pc);
    else n_pass++;
    halt_addr = NO_HALT;
  endtask

  task automatic test_wrap();
    int n;
    ir_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!(ir_valid && ir_pc == 64'h0) && n < 60) begin tick(); n++; end
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 64'h0 || ir !== mem_word(64'h0))
      $display("FAIL wrap_zero: v=%b ir=%h pc=%h, need 1 %h 0", ir_valid, ir, ir_pc, mem_word(64'h0));
    else n_pass++;
    ir_ready = 1'b0;
  endtask

  task automatic test_random();
    int hs0;
    ready_pct = 60; min_lat = 0; max_lat = 3;
    halt_addr = 64'h8000 + 64'($urandom_range(1023)) * 64'd4;
    hs0 = n_hs;
    for (int i = 0; i < 3000; i++) begin
      ir_ready       = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = 64'($urandom_range(65535));
      tick();
    end
    redirect_valid = 1'b0;
    ir_ready = 1'b0;
    n_checks++;
    if (n_hs - hs0 < 200)
      $display("FAIL random_progress: handshakes=%0d, need >= 200", n_hs - hs0);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    int n;
    ready_pct = 100; min_lat = 0; max_lat = 0;
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    reset = 1'b1;
    tick();
    n_checks++;
    if (rd_req_valid !== 1'b0 || rd_req_addr !== 64'h0 || ir_valid !== 1'b0 ||
        ir !== 32'h0 || ir_pc !== 64'h0 || halted !== 1'b0)
      $display("FAIL drain_reset: req=%b addr=%h irv=%b ir=%h pc=%h halted=%b, need all 0",
               rd_req_valid, rd_req_addr, ir_valid, ir, ir_pc, halted);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (rd_req_valid !== 1'b1 || rd_req_addr !== ENTRY)
      $display("FAIL drain_reset_req: req=%b addr=%h, need 1 %h", rd_req_valid, rd_req_addr, ENTRY);
    else n_pass++;
    n = 0;
    while (!ir_valid && n < 30) begin tick(); n++; end
    n_checks++;
    if (ir !== 32'h0010_0093 || ir_pc !== ENTRY)
      $display("FAIL drain_reset_ir: ir=%h pc=%h, need 00100093 %h", ir, ir_pc, ENTRY);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; n_hs = 0;
    reset = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rd_req_ready = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0;
    ready_pct = 100; min_lat = 0; max_lat = 0; halt_addr = NO_HALT;
    pending = 1'b0; pend_addr = '0; lat_cnt = 0; m_pc = ENTRY; m_halted = 1'b0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_misaligned_redirect();
    test_redirect_in_wait();
    test_halt();
    test_wrap();
    test_random();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
